tt_um_serial_adder: RTL and testbench

Parametrised bit-serial adder/subtractor tile, the sequential successor to the single-bit half adder. Operands of WIDTH bits are loaded over the 8-bit dedicated input bus and summed LSB-first through one full-adder cell and a carry flop, WIDTH cycles per operation. A ready/busy/done handshake sits on the bidirectional pins, with add, subtract and accumulate modes. The block is a standalone Tiny Tapeout user tile.

---
 rtl/tt_um_serial_adder.sv | 154 +++++++++++++++
 tb/tb_tt_um_serial_adder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_um_serial_adder.sv
// Bit-serial adder/subtractor tile: WIDTH-bit operands summed LSB-first through
// one full-adder cell and a carry flop, with add, subtract and accumulate modes.
module tt_um_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Handshake: start is a level sampled on every enabled edge in IDLE/DONE; busy
  // is high for exactly WIDTH enabled edges; done holds with R/flag until the
  // next start or load. start and loads seen while busy are dropped, not queued.

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             f_q, f_d;
  logic             m_q, m_d;

  logic             load_a, load_b, start, sub, acc;
  logic [WIDTH-1:0] operand;
  logic             sum_bit;
  logic             cout;
  logic             last_step;
  logic [WIDTH-1:0] s_shift;
  logic             unused_ok;

  assign load_a  = uio_in[0];
  assign load_b  = uio_in[1];
  assign start   = uio_in[2];
  assign sub     = uio_in[3];
  assign acc     = uio_in[4];
  assign operand = ui_in[WIDTH-1:0];

  // Bits of the buses that carry no meaning for this tile.
  assign unused_ok = &{1'b0, ui_in, uio_in[7:5]};

  assign sum_bit   = sa_q[0] ^ sb_q[0] ^ c_q;
  assign cout      = (sa_q[0] & sb_q[0]) | (sa_q[0] & c_q) | (sb_q[0] & c_q);
  assign last_step = (cnt_q == CW'(WIDTH - 1));

  // New sum bit enters at the MSB so that after WIDTH steps S holds the LSB at bit 0.
  generate
    if (WIDTH == 1) begin : g_shift_w1
      assign s_shift = sum_bit;
    end else begin : g_shift_wn
      assign s_shift = {sum_bit, s_q[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sa_q    <= '0;
      sb_q    <= '0;
      s_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      f_q     <= 1'b0;
      m_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      s_q     <= s_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      f_q     <= f_d;
      m_q     <= m_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    s_d     = s_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    f_d     = f_q;
    m_d     = m_q;

    if (ena) begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            // Subtract is A + ~B + 1: invert B and seed the carry with 1.
            sa_d    = acc ? r_q : a_q;
            sb_d    = sub ? ~b_q : b_q;
            c_d     = sub;
            m_d     = sub;
            cnt_d   = '0;
            s_d     = '0;
            state_d = ST_RUN;
          end else begin
            if (load_a) a_d = operand;
            if (load_b) b_d = operand;
            if ((state_q == ST_DONE) && (load_a || load_b)) state_d = ST_IDLE;
          end
        end

        ST_RUN: begin
          c_d   = cout;
          sa_d  = sa_q >> 1;
          sb_d  = sb_q >> 1;
          s_d   = s_shift;
          cnt_d = cnt_q + 1'b1;
          if (last_step) begin
            // In subtract mode a missing carry-out means a borrow.
            r_d     = s_shift;
            f_d     = m_q ? ~cout : cout;
            state_d = ST_DONE;
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign uo_out  = 8'(r_q);
  assign uio_out = {f_q, (state_q == ST_DONE), (state_q == ST_RUN), 5'b0_0000};
  assign uio_oe  = 8'b1110_0000;

endmodule

// File: tb/tb_tt_um_serial_adder.sv
// Bench for tt_um_serial_adder: an 8-bit and a 4-bit instance share one stimulus
// stream and are checked against an arithmetic reference model.
module tb_tt_um_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo8, uio_out8, uio_oe8;
  logic [7:0] uo4, uio_out4, uio_oe4;

  int checks = 0;
  int errors = 0;

  // Reference model state, index 0 = WIDTH 8, index 1 = WIDTH 4.
  logic [31:0] ma[2], mb[2], mr[2], mf[2];

  always #5 clk = ~clk;

  tt_um_serial_adder #(.WIDTH(8)) dut8 (
    .ui_in(ui_in), .uo_out(uo8), .uio_in(uio_in), .uio_out(uio_out8),
    .uio_oe(uio_oe8), .ena(ena), .clk(clk), .rst_n(rst_n)
  );

  tt_um_serial_adder #(.WIDTH(4)) dut4 (
    .ui_in(ui_in), .uo_out(uo4), .uio_in(uio_in), .uio_out(uio_out4),
    .uio_oe(uio_oe4), .ena(ena), .clk(clk), .rst_n(rst_n)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic int wid(int i);
    return (i == 0) ? 8 : 4;
  endfunction

  function automatic logic [31:0] msk(int i);
    return (i == 0) ? 32'hFF : 32'h0F;
  endfunction

  function automatic logic [7:0] get_uo(int i);
    return (i == 0) ? uo8 : uo4;
  endfunction

  function automatic logic [7:0] get_uio(int i);
    return (i == 0) ? uio_out8 : uio_out4;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      ma[i] = 0; mb[i] = 0; mr[i] = 0; mf[i] = 0;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s_w%0d_busy", tag, wid(i)), 32'(get_uio(i)[5]), 0);
      check($sformatf("%s_w%0d_done", tag, wid(i)), 32'(get_uio(i)[6]), 0);
    end
  endtask

  task automatic do_load(input logic la, input logic lb, input logic [7:0] d);
    @(negedge clk);
    ui_in  = d;
    uio_in = {3'($urandom), 3'b000, lb, la};
    for (int i = 0; i < 2; i++) begin
      if (la) ma[i] = 32'(d) & msk(i);
      if (lb) mb[i] = 32'(d) & msk(i);
    end
    @(negedge clk);
    uio_in = {3'($urandom), 5'b0};
    check_idle_outputs("after_load");
  endtask

  // One operation: start pulse, then watch both instances until done.
  task automatic run_op(input logic sub, input logic acc, input logic load_with_start,
                        input int gap_at, input int gap_len,
                        input int inj_at, input logic [7:0] inj_d);
    logic [31:0] x, full, exp_r[2], exp_f[2], prev_r[2];
    int done_t[2], busy_n[2], exp_lat[2];
    for (int i = 0; i < 2; i++) begin
      x = acc ? mr[i] : ma[i];
      if (sub) begin
        exp_r[i] = (x - mb[i]) & msk(i);
        exp_f[i] = (x < mb[i]) ? 1 : 0;
      end else begin
        full     = x + mb[i];
        exp_r[i] = full & msk(i);
        exp_f[i] = full >> wid(i);
      end
      prev_r[i]  = mr[i];
      done_t[i]  = -1;
      busy_n[i]  = 0;
      exp_lat[i] = wid(i) + ((gap_at >= 0) ? gap_len : 0);
    end
    @(negedge clk);
    ui_in  = 8'($urandom);
    uio_in = {3'($urandom), acc, sub, 1'b1, 1'b0, load_with_start};
    @(negedge clk);
    uio_in = {3'($urandom), 5'b0};
    for (int t = 0; t < 60; t++) begin
      for (int i = 0; i < 2; i++) begin
        if (done_t[i] < 0) begin
          if (get_uio(i)[6]) done_t[i] = t;
          else begin
            busy_n[i] += int'(get_uio(i)[5]);
            check($sformatf("no_partial_w%0d", wid(i)), 32'(get_uo(i)), prev_r[i]);
          end
        end
      end
      if (t == gap_at) ena = 1'b0;
      if (t == gap_at + gap_len) ena = 1'b1;
      if (t == inj_at) begin
        ui_in  = inj_d;
        uio_in = {3'($urandom), 2'b00, 1'b1, 1'b0, 1'b1};
      end else if (t == inj_at + 1) begin
        uio_in = {3'($urandom), 5'b0};
      end
      if (done_t[0] >= 0 && done_t[1] >= 0 && t > inj_at + 1) break;
      @(negedge clk);
    end
    uio_in = {3'($urandom), 5'b0};
    ena    = 1'b1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("latency_w%0d", wid(i)), 32'(done_t[i]), 32'(exp_lat[i]));
      check($sformatf("busy_cycles_w%0d", wid(i)), 32'(busy_n[i]), 32'(exp_lat[i]));
      check($sformatf("result_w%0d", wid(i)), 32'(get_uo(i)), exp_r[i]);
      check($sformatf("flag_w%0d", wid(i)), 32'(get_uio(i)[7]), exp_f[i]);
      check($sformatf("uio_low_w%0d", wid(i)), 32'(get_uio(i)[4:0]), 0);
      mr[i] = exp_r[i];
      mf[i] = exp_f[i];
    end
  endtask

  initial begin
    logic       la, lb;
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset_uo_w%0d", wid(i)), 32'(get_uo(i)), 0);
      check($sformatf("reset_uio_w%0d", wid(i)), 32'(get_uio(i)), 0);
    end
    check("uio_oe_w8", 32'(uio_oe8), 32'hE0);
    check("uio_oe_w4", 32'(uio_oe4), 32'hE0);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("post_reset");

    // Basic add, accumulate twice.
    do_load(1'b1, 1'b0, 8'h5A);
    do_load(1'b0, 1'b1, 8'h3C);
    run_op(1'b0, 1'b0, 1'b0, -1, 0, -10, 8'h00);
    check("add_5a_3c", 32'(uo8), 32'h96);
    do_load(1'b0, 1'b1, 8'h70);
    run_op(1'b0, 1'b1, 1'b0, -1, 0, -10, 8'h00);
    check("acc1", 32'(uo8), 32'h06);
    run_op(1'b0, 1'b1, 1'b0, -1, 0, -10, 8'h00);
    check("acc2", 32'(uo8), 32'h76);

    // Overflow and subtract in both directions.
    do_load(1'b1, 1'b0, 8'hFF);
    do_load(1'b0, 1'b1, 8'h01);
    run_op(1'b0, 1'b0, 1'b0, -1, 0, -10, 8'h00);
    do_load(1'b1, 1'b0, 8'h10);
    do_load(1'b0, 1'b1, 8'h20);
    run_op(1'b1, 1'b0, 1'b0, -1, 0, -10, 8'h00);
    check("sub_10_20", 32'(uo8), 32'hF0);
    do_load(1'b1, 1'b0, 8'h20);
    do_load(1'b0, 1'b1, 8'h10);
    run_op(1'b1, 1'b0, 1'b0, -1, 0, -10, 8'h00);

    // Start and load_a pulsed mid-run are dropped; A must survive for a rerun.
    do_load(1'b1, 1'b0, 8'h33);
    do_load(1'b0, 1'b1, 8'h11);
    run_op(1'b0, 1'b0, 1'b0, -1, 0, 1, 8'hAA);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("no_rerun_busy_w%0d", wid(i)), 32'(get_uio(i)[5]), 0);
      check($sformatf("no_rerun_done_w%0d", wid(i)), 32'(get_uio(i)[6]), 1);
    end
    run_op(1'b0, 1'b0, 1'b0, -1, 0, -10, 8'h00);
    check("a_kept", 32'(uo8), 32'h44);

    // load_a together with start in IDLE: start wins, old A is used.
    do_load(1'b0, 1'b1, 8'h05);
    run_op(1'b0, 1'b0, 1'b1, -1, 0, -10, 8'h00);

    // Enable dropped for 5 cycles mid-run.
    run_op(1'b1, 1'b0, 1'b0, 2, 5, -10, 8'h00);

    // Asynchronous reset in the middle of a run.
    do_load(1'b1, 1'b0, 8'hC3);
    run_op(1'b0, 1'b0, 1'b0, -1, 0, -10, 8'h00);
    @(negedge clk);
    uio_in = 8'h04;
    @(negedge clk);
    uio_in = 8'h00;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("midrun_rst_uo_w%0d", wid(i)), 32'(get_uo(i)), 0);
      check($sformatf("midrun_rst_uio_w%0d", wid(i)), 32'(get_uio(i)), 0);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("post_midrun_reset");

    // Narrow-width cases; upper bus bits must be ignored by the 4-bit tile.
    do_load(1'b1, 1'b0, 8'h0F);
    do_load(1'b0, 1'b1, 8'h01);
    run_op(1'b0, 1'b0, 1'b0, -1, 0, -10, 8'h00);
    check("w4_f_plus_1", 32'(uo4), 32'h00);
    do_load(1'b1, 1'b0, 8'hF3);
    run_op(1'b0, 1'b0, 1'b0, -1, 0, -10, 8'h00);
    check("w4_masked_a", 32'(uo4), 32'h04);

    // Randomized operations, loads and modes.
    for (int n = 0; n < 40; n++) begin
      la = 1'($urandom);
      lb = 1'($urandom);
      if (!la && !lb) la = 1'b1;
      if (la && lb && ($urandom_range(0, 1) == 1)) begin
        do_load(1'b1, 1'b1, 8'($urandom));
      end else begin
        if (la) do_load(1'b1, 1'b0, 8'($urandom));
        if (lb) do_load(1'b0, 1'b1, 8'($urandom));
      end
      run_op(1'($urandom), 1'($urandom), 1'b0,
             ($urandom_range(0, 3) == 0) ? 1 : -1, $urandom_range(1, 4), -10, 8'h00);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
